bscan_local_mux: RTL and testbench

- Parametrised successor of the single-channel BSCAN local shift register. Multiplexes CHANNELS logical streams over one BSCANE2 USER data register.
- Per-channel transmit FIFOs toward the JTAG host and a receive FIFO toward fabric. Updates are absorbed instead of lost when the consumer stalls, and overflow is reported in-band.
- Clocked by the BUFG-buffered TCK; sits between the BSCANE2 primitive wrapper and the fabric consumers.

---
 rtl/bscan_local_mux.sv | 188 ++++++++++++++++++
 tb/tb_bscan_local_mux.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bscan_local_mux.sv
// bscan_local_mux: multiplexes CHANNELS logical streams over one BSCANE2 USER
// data register. Each channel has its own transmit FIFO toward the JTAG host.
// A shared receive FIFO carries {chan,data} toward the fabric. When the
// receive FIFO is full, dropped frames are counted and flagged in-band.
module bscan_local_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 8
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             capture,
  input  logic             shift,
  input  logic             update,
  input  logic             TDI,
  output logic             TDO,
  input  logic             toBscan_enq__ENA,
  input  logic [WIDTH-1:0] toBscan_enq_v,
  input  logic [CW-1:0]    toBscan_enq_chan,
  output logic             toBscan_enq__RDY,
  output logic             fromBscan_enq__ENA,
  output logic [WIDTH-1:0] fromBscan_enq_v,
  output logic [CW-1:0]    fromBscan_enq_chan,
  input  logic             fromBscan_enq__RDY,
  output logic [15:0]      rx_drop_count
);

  localparam int L   = WIDTH + CW + 2;
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int RXW = CW + WIDTH;
  localparam logic [TXA:0] TX_FULL  = (TXA + 1)'(TX_DEPTH);
  localparam logic [RXA:0] RX_FULL  = (RXA + 1)'(RX_DEPTH);
  localparam logic [CW:0]  CH_LIMIT = (CW + 1)'(CHANNELS);

  logic [L-1:0]     r_sr;
  logic [CW-1:0]    r_pollChan;
  logic             r_ovfSticky;
  logic [15:0]      r_dropCount;

  logic [WIDTH-1:0] r_txMem   [CHANNELS][TX_DEPTH];
  logic [TXA-1:0]   r_txRd    [CHANNELS];
  logic [TXA-1:0]   r_txWr    [CHANNELS];
  logic [TXA:0]     r_txCount [CHANNELS];

  logic [RXW-1:0]   r_rxMem   [RX_DEPTH];
  logic [RXA-1:0]   r_rxRd;
  logic [RXA-1:0]   r_rxWr;
  logic [RXA:0]     r_rxCount;

  // Only the highest-priority strobe acts: capture > shift > update.
  logic w_doCapture, w_doShift, w_doUpdate;
  assign w_doCapture = capture;
  assign w_doShift   = shift & ~capture;
  assign w_doUpdate  = update & ~capture & ~shift;

  // The polled channel's FIFO is popped into the frame whenever it has data.
  logic             w_pollNe, w_txPop;
  logic [WIDTH-1:0] w_txHead;
  assign w_pollNe = (r_txCount[r_pollChan] != '0);
  assign w_txHead = w_pollNe ? r_txMem[r_pollChan][r_txRd[r_pollChan]] : '0;
  assign w_txPop  = w_doCapture & w_pollNe;

  // A full FIFO still takes a push when the same entry is being popped.
  logic w_enqInRange, w_enqFull, w_txPush;
  assign w_enqInRange = ({1'b0, toBscan_enq_chan} < CH_LIMIT);
  assign w_enqFull    = w_enqInRange && (r_txCount[toBscan_enq_chan] == TX_FULL);
  assign w_txPush     = toBscan_enq__ENA & w_enqInRange &
                        (~w_enqFull | (w_txPop & (toBscan_enq_chan == r_pollChan)));
  assign toBscan_enq__RDY = w_enqInRange & ~w_enqFull;

  // Decoded fields of the host frame; an out-of-range channel voids the frame.
  logic             w_updValid, w_updInRange;
  logic [CW-1:0]    w_updChan;
  logic [WIDTH-1:0] w_updData;
  assign w_updValid   = r_sr[0];
  assign w_updChan    = r_sr[CW:1];
  assign w_updData    = r_sr[CW+WIDTH:CW+1];
  assign w_updInRange = ({1'b0, w_updChan} < CH_LIMIT);

  // Receive FIFO: a pop in the same cycle frees the slot for an update push.
  logic w_rxNe, w_rxFull, w_rxPop, w_rxPush, w_drop;
  assign w_rxNe   = (r_rxCount != '0);
  assign w_rxFull = (r_rxCount == RX_FULL);
  assign w_rxPop  = w_rxNe & fromBscan_enq__RDY;
  assign w_rxPush = w_doUpdate & w_updInRange & w_updValid & (~w_rxFull | w_rxPop);
  assign w_drop   = w_doUpdate & w_updInRange & w_updValid & w_rxFull & ~w_rxPop;

  assign TDO                = r_sr[0];
  assign fromBscan_enq__ENA = w_rxNe;
  assign {fromBscan_enq_chan, fromBscan_enq_v} = r_rxMem[r_rxRd];
  assign rx_drop_count      = r_dropCount;

  // Scan register: parallel load on capture, LSB-first shift otherwise.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_sr <= '0;
    end else if (w_doCapture) begin
      r_sr <= {r_ovfSticky, w_txHead, r_pollChan, w_pollNe};
    end else if (w_doShift) begin
      r_sr <= {TDI, r_sr[L-1:1]};
    end
  end

  // Poll channel, overflow flag and saturating drop counter.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_pollChan  <= '0;
      r_ovfSticky <= 1'b0;
      r_dropCount <= '0;
    end else begin
      if (w_doUpdate && w_updInRange) begin
        r_pollChan <= w_updChan;
      end
      if (w_drop) begin
        r_ovfSticky <= 1'b1;
      end else if (w_doCapture) begin
        r_ovfSticky <= 1'b0;
      end
      if (w_drop && (r_dropCount != 16'hFFFF)) begin
        r_dropCount <= r_dropCount + 16'd1;
      end
    end
  end

  // Transmit FIFO pointers and occupancy, one set per channel.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_txRd[c]    <= '0;
        r_txWr[c]    <= '0;
        r_txCount[c] <= '0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_txPush && (toBscan_enq_chan == CW'(c))) begin
          r_txWr[c] <= r_txWr[c] + 1'b1;
        end
        if (w_txPop && (r_pollChan == CW'(c))) begin
          r_txRd[c] <= r_txRd[c] + 1'b1;
        end
        if ((w_txPush && (toBscan_enq_chan == CW'(c))) && !(w_txPop && (r_pollChan == CW'(c)))) begin
          r_txCount[c] <= r_txCount[c] + 1'b1;
        end else if (!(w_txPush && (toBscan_enq_chan == CW'(c))) && (w_txPop && (r_pollChan == CW'(c)))) begin
          r_txCount[c] <= r_txCount[c] - 1'b1;
        end
      end
    end
  end

  // Transmit FIFO storage; contents need no reset since occupancy gates reads.
  always_ff @(posedge CLK) begin
    if (w_txPush) begin
      r_txMem[toBscan_enq_chan][r_txWr[toBscan_enq_chan]] <= toBscan_enq_v;
    end
  end

  // Receive FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      r_rxRd    <= '0;
      r_rxWr    <= '0;
      r_rxCount <= '0;
    end else begin
      if (w_rxPush) begin
        r_rxWr <= r_rxWr + 1'b1;
      end
      if (w_rxPop) begin
        r_rxRd <= r_rxRd + 1'b1;
      end
      if (w_rxPush && !w_rxPop) begin
        r_rxCount <= r_rxCount + 1'b1;
      end else if (!w_rxPush && w_rxPop) begin
        r_rxCount <= r_rxCount - 1'b1;
      end
    end
  end

  // Receive FIFO storage.
  always_ff @(posedge CLK) begin
    if (w_rxPush) begin
      r_rxMem[r_rxWr] <= {w_updChan, w_updData};
    end
  end

endmodule

// File: tb/tb_bscan_local_mux.sv
// Directed bench for bscan_local_mux. A second instance with CHANNELS=3
// shares all inputs so that an unrepresentable-by-default out-of-range
// channel (3) can be exercised.
module tb_bscan_local_mux;

  localparam int L = 36;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        capture, shift, update, TDI;
  logic        toBscan_enq__ENA;
  logic [31:0] toBscan_enq_v;
  logic [1:0]  toBscan_enq_chan;
  logic        fromBscan_enq__RDY;

  logic        TDO, toBscan_enq__RDY, fromBscan_enq__ENA;
  logic [31:0] fromBscan_enq_v;
  logic [1:0]  fromBscan_enq_chan;
  logic [15:0] rx_drop_count;

  logic        d3Tdo, d3TxRdy, d3RxEna;
  logic [31:0] d3RxV;
  logic [1:0]  d3RxChan;
  logic [15:0] d3Drop;

  int total = 0;
  int bad   = 0;

  logic [L-1:0] outFrame, outFrame3;

  bscan_local_mux u_dut (
    .CLK(CLK), .nRST(nRST), .capture(capture), .shift(shift), .update(update),
    .TDI(TDI), .TDO(TDO),
    .toBscan_enq__ENA(toBscan_enq__ENA), .toBscan_enq_v(toBscan_enq_v),
    .toBscan_enq_chan(toBscan_enq_chan), .toBscan_enq__RDY(toBscan_enq__RDY),
    .fromBscan_enq__ENA(fromBscan_enq__ENA), .fromBscan_enq_v(fromBscan_enq_v),
    .fromBscan_enq_chan(fromBscan_enq_chan), .fromBscan_enq__RDY(fromBscan_enq__RDY),
    .rx_drop_count(rx_drop_count)
  );

  bscan_local_mux #(.CHANNELS(3)) u_dut3 (
    .CLK(CLK), .nRST(nRST), .capture(capture), .shift(shift), .update(update),
    .TDI(TDI), .TDO(d3Tdo),
    .toBscan_enq__ENA(toBscan_enq__ENA), .toBscan_enq_v(toBscan_enq_v),
    .toBscan_enq_chan(toBscan_enq_chan), .toBscan_enq__RDY(d3TxRdy),
    .fromBscan_enq__ENA(d3RxEna), .fromBscan_enq_v(d3RxV),
    .fromBscan_enq_chan(d3RxChan), .fromBscan_enq__RDY(fromBscan_enq__RDY),
    .rx_drop_count(d3Drop)
  );

  // Free-running buffered-TCK stand-in.
  always #5 CLK = ~CLK;

  function automatic logic [L-1:0] mkFrame(input logic v, input logic [1:0] ch,
                                           input logic [31:0] d, input logic f);
    return {f, d, ch, v};
  endfunction

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] ch, input logic [31:0] v);
    toBscan_enq__ENA = 1'b1;
    toBscan_enq_chan = ch;
    toBscan_enq_v    = v;
    tick();
    toBscan_enq__ENA = 1'b0;
  endtask

  // Shift a whole frame through both DUTs and then pulse update.
  task automatic shiftUpdate(input logic [L-1:0] inF, output logic [L-1:0] outF,
                             output logic [L-1:0] outF3);
    shift = 1'b1;
    for (int i = 0; i < L; i++) begin
      TDI      = inF[i];
      outF[i]  = TDO;
      outF3[i] = d3Tdo;
      tick();
    end
    shift  = 1'b0;
    TDI    = 1'b0;
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic scanFrame(input logic [L-1:0] inF, output logic [L-1:0] outF,
                           output logic [L-1:0] outF3);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    shiftUpdate(inF, outF, outF3);
  endtask

  initial begin
    nRST = 1'b1; capture = 1'b0; shift = 1'b0; update = 1'b0; TDI = 1'b0;
    toBscan_enq__ENA = 1'b0; toBscan_enq_v = '0; toBscan_enq_chan = '0;
    fromBscan_enq__RDY = 1'b1;
    tick();
    tick();
    nRST = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_tdo", 64'(TDO), 64'd0);
    checkOutput("rst_rxena", 64'(fromBscan_enq__ENA), 64'd0);
    checkOutput("rst_txrdy", 64'(toBscan_enq__RDY), 64'd1);
    checkOutput("rst_drop", 64'(rx_drop_count), 64'd0);

    $display("[TB] loopback");
    applyStimulus(2'd2, 32'hDEADBEEF);
    scanFrame(mkFrame(1'b0, 2'd2, 32'h0, 1'b0), outFrame, outFrame3);
    checkOutput("lb_first_poll0", 64'(outFrame), 64'(mkFrame(1'b0, 2'd0, 32'h0, 1'b0)));
    scanFrame(mkFrame(1'b0, 2'd1, 32'h0, 1'b0), outFrame, outFrame3);
    checkOutput("lb_frame", 64'(outFrame), 64'(mkFrame(1'b1, 2'd2, 32'hDEADBEEF, 1'b0)));

    $display("[TB] empty poll");
    scanFrame(mkFrame(1'b0, 2'd2, 32'h0, 1'b0), outFrame, outFrame3);
    checkOutput("empty_poll1", 64'(outFrame), 64'(mkFrame(1'b0, 2'd1, 32'h0, 1'b0)));
    checkOutput("rx_idle", 64'(fromBscan_enq__ENA), 64'd0);
    scanFrame(mkFrame(1'b1, 2'd3, 32'h12345678, 1'b0), outFrame, outFrame3);
    checkOutput("lb_ch2_empty", 64'(outFrame), 64'(mkFrame(1'b0, 2'd2, 32'h0, 1'b0)));

    $display("[TB] receive path");
    checkOutput("rx_ena", 64'(fromBscan_enq__ENA), 64'd1);
    checkOutput("rx_chan", 64'(fromBscan_enq_chan), 64'd3);
    checkOutput("rx_data", 64'(fromBscan_enq_v), 64'h12345678);
    tick();
    checkOutput("rx_ena_1cyc", 64'(fromBscan_enq__ENA), 64'd0);

    $display("[TB] overflow");
    fromBscan_enq__RDY = 1'b0;
    for (int i = 0; i < 10; i++) begin
      scanFrame(mkFrame(1'b1, 2'(i % 4), 32'hA0000000 + 32'(i), 1'b0), outFrame, outFrame3);
    end
    checkOutput("ovf_drop", 64'(rx_drop_count), 64'd2);
    scanFrame(mkFrame(1'b0, 2'd0, 32'h0, 1'b0), outFrame, outFrame3);
    checkOutput("ovf_flag_set", 64'(outFrame), 64'(mkFrame(1'b0, 2'd1, 32'h0, 1'b1)));
    scanFrame(mkFrame(1'b0, 2'd0, 32'h0, 1'b0), outFrame, outFrame3);
    checkOutput("ovf_flag_clr", 64'(outFrame), 64'(mkFrame(1'b0, 2'd0, 32'h0, 1'b0)));
    fromBscan_enq__RDY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("ovf_ena%0d", i), 64'(fromBscan_enq__ENA), 64'd1);
      checkOutput($sformatf("ovf_data%0d", i), 64'(fromBscan_enq_v), 64'(32'hA0000000 + 32'(i)));
      checkOutput($sformatf("ovf_chan%0d", i), 64'(fromBscan_enq_chan), 64'(i % 4));
      tick();
    end
    checkOutput("ovf_drained", 64'(fromBscan_enq__ENA), 64'd0);

    $display("[TB] transmit boundaries");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'd0, 32'h100 + 32'(k));
    end
    toBscan_enq_chan = 2'd0;
    checkOutput("tx_full_rdy", 64'(toBscan_enq__RDY), 64'd0);
    toBscan_enq__ENA = 1'b1;
    toBscan_enq_v    = 32'h104;
    capture          = 1'b1;
    tick();
    toBscan_enq__ENA = 1'b0;
    capture          = 1'b0;
    checkOutput("tx_still_full", 64'(toBscan_enq__RDY), 64'd0);
    shiftUpdate(mkFrame(1'b0, 2'd0, 32'h0, 1'b0), outFrame, outFrame3);
    checkOutput("tx_cap0", 64'(outFrame), 64'(mkFrame(1'b1, 2'd0, 32'h100, 1'b0)));
    for (int k = 1; k <= 4; k++) begin
      scanFrame(mkFrame(1'b0, 2'd0, 32'h0, 1'b0), outFrame, outFrame3);
      checkOutput($sformatf("tx_cap%0d", k), 64'(outFrame), 64'(mkFrame(1'b1, 2'd0, 32'h100 + 32'(k), 1'b0)));
    end
    scanFrame(mkFrame(1'b0, 2'd0, 32'h0, 1'b0), outFrame, outFrame3);
    checkOutput("tx_empty", 64'(outFrame), 64'(mkFrame(1'b0, 2'd0, 32'h0, 1'b0)));
    checkOutput("tx_rdy_again", 64'(toBscan_enq__RDY), 64'd1);

    $display("[TB] reset mid-shift");
    applyStimulus(2'd1, 32'h0000CAFE);
    fromBscan_enq__RDY = 1'b0;
    scanFrame(mkFrame(1'b1, 2'd0, 32'h77, 1'b0), outFrame, outFrame3);
    checkOutput("mid_rx_queued", 64'(fromBscan_enq__ENA), 64'd1);
    applyStimulus(2'd0, 32'hFFFFFFFF);
    capture = 1'b1;
    tick();
    capture = 1'b0;
    shift   = 1'b1;
    TDI     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    checkOutput("mid_tdo_before", 64'(TDO), 64'd1);
    nRST = 1'b1;
    tick();
    nRST  = 1'b0;
    shift = 1'b0;
    TDI   = 1'b0;
    checkOutput("mid_tdo", 64'(TDO), 64'd0);
    checkOutput("mid_rxena", 64'(fromBscan_enq__ENA), 64'd0);
    checkOutput("mid_drop", 64'(rx_drop_count), 64'd0);
    fromBscan_enq__RDY = 1'b1;
    scanFrame(mkFrame(1'b0, 2'd1, 32'h0, 1'b0), outFrame, outFrame3);
    checkOutput("mid_ch0_empty", 64'(outFrame), 64'(mkFrame(1'b0, 2'd0, 32'h0, 1'b0)));

    $display("[TB] out-of-range channel");
    scanFrame(mkFrame(1'b1, 2'd3, 32'h55, 1'b0), outFrame, outFrame3);
    checkOutput("mid_ch1_empty", 64'(outFrame), 64'(mkFrame(1'b0, 2'd1, 32'h0, 1'b0)));
    checkOutput("d3_cap", 64'(outFrame3), 64'(mkFrame(1'b0, 2'd1, 32'h0, 1'b0)));
    checkOutput("oor_main_rx", 64'(fromBscan_enq__ENA), 64'd1);
    checkOutput("oor_d3_rx", 64'(d3RxEna), 64'd0);
    tick();
    scanFrame(mkFrame(1'b0, 2'd0, 32'h0, 1'b0), outFrame, outFrame3);
    checkOutput("oor_main_poll", 64'(outFrame), 64'(mkFrame(1'b0, 2'd3, 32'h0, 1'b0)));
    checkOutput("oor_d3_poll", 64'(outFrame3), 64'(mkFrame(1'b0, 2'd1, 32'h0, 1'b0)));
    checkOutput("oor_d3_drop", 64'(d3Drop), 64'd0);
    toBscan_enq_chan = 2'd3;
    #1;
    checkOutput("oor_main_txrdy", 64'(toBscan_enq__RDY), 64'd1);
    checkOutput("oor_d3_txrdy", 64'(d3TxRdy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
